// File: rtl/dwrr_scheduler.sv
// dwrr_scheduler: deficit-weighted round-robin scheduler for output flows.
// Keeps a saturating credit counter per flow and grants one packet at a time
// to a requesting flow that still has credit. When no requesting flow has
// credit, it fetches the next flow number from the credit-order table and
// adds QUANTUM credits to that flow.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flow_req        per-flow "packet queued" flags
//   grant_valid/    grant offer and granted flow (held until grant_ready)
//   grant_flow
//   grant_ready     datapath accepts the grant
//   pkt_done/       end of the granted packet and its credit cost
//   pkt_cost
//   ord_init_done   credit-order table ready
//   ord_rd_req      one-cycle pulse reading the next table entry
//   ord_flow        table output, valid two cycles after ord_rd_req
//   dbg_flow/       combinational credit read-back
//   dbg_credit
module dwrr_scheduler #(
   parameter int FLOW_W       = 3,
   parameter int MAX_CREDIT_W = 3,
   parameter int QUANTUM      = 4,
   localparam int unsigned NUM_FLOWS = 2**FLOW_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_FLOWS-1:0]    flow_req,
   output logic                    grant_valid,
   output logic [FLOW_W-1:0]       grant_flow,
   input  logic                    grant_ready,
   input  logic                    pkt_done,
   input  logic [MAX_CREDIT_W-1:0] pkt_cost,
   input  logic                    ord_init_done,
   output logic                    ord_rd_req,
   input  logic [FLOW_W-1:0]       ord_flow,
   input  logic [FLOW_W-1:0]       dbg_flow,
   output logic [MAX_CREDIT_W-1:0] dbg_credit
);

   typedef enum logic [2:0] {
      S_INIT,
      S_SELECT,
      S_GRANT,
      S_BUSY,
      S_REFILL,
      S_WAIT1,
      S_WAIT2
   } state_t;

   localparam logic [MAX_CREDIT_W:0] CREDIT_MAX  = {1'b0, {MAX_CREDIT_W{1'b1}}};
   localparam logic [MAX_CREDIT_W:0] QUANTUM_EXT = (MAX_CREDIT_W+1)'(QUANTUM);

   state_t                  state_q, state_d;
   logic [MAX_CREDIT_W-1:0] credit_q [NUM_FLOWS];
   logic [MAX_CREDIT_W-1:0] credit_d [NUM_FLOWS];
   logic [FLOW_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic                    grant_valid_q, grant_valid_d;
   logic [FLOW_W-1:0]       grant_flow_q, grant_flow_d;

   logic                    pick_found;
   logic [FLOW_W-1:0]       pick_flow;
   logic [FLOW_W-1:0]       pick_idx;
   logic [MAX_CREDIT_W:0]   spend_diff;
   logic [MAX_CREDIT_W:0]   refill_sum;

   // Round-robin search starting just after the last served flow; the index
   // wraps naturally through the FLOW_W-bit truncation.
   always_comb begin
      pick_found = 1'b0;
      pick_flow  = '0;
      pick_idx   = '0;
      for (int unsigned i = 1; i <= NUM_FLOWS; i++) begin
         pick_idx = rr_ptr_q + FLOW_W'(i);
         if (!pick_found && flow_req[pick_idx] && (credit_q[pick_idx] != '0)) begin
            pick_found = 1'b1;
            pick_flow  = pick_idx;
         end
      end
   end

   // One extra bit of headroom: a borrow out of the subtract means "clamp to
   // zero", a carry past CREDIT_MAX on the add means "clamp to max".
   always_comb begin
      spend_diff = {1'b0, credit_q[grant_flow_q]} - {1'b0, pkt_cost};
      refill_sum = {1'b0, credit_q[ord_flow]} + QUANTUM_EXT;
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      rr_ptr_d      = rr_ptr_q;
      grant_valid_d = grant_valid_q;
      grant_flow_d  = grant_flow_q;

      case (state_q)
         S_INIT: begin
            if (ord_init_done) begin
               state_d = S_SELECT;
            end
         end

         S_SELECT: begin
            // Idle flows forfeit any leftover credit.
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
               if (!flow_req[f]) begin
                  credit_d[f] = '0;
               end
            end
            if (pick_found) begin
               grant_flow_d  = pick_flow;
               grant_valid_d = 1'b1;
               state_d       = S_GRANT;
            end else if (flow_req != '0) begin
               state_d = S_REFILL;
            end
         end

         S_GRANT: begin
            if (grant_ready) begin
               grant_valid_d = 1'b0;
               state_d       = S_BUSY;
            end
         end

         S_BUSY: begin
            if (pkt_done) begin
               credit_d[grant_flow_q] = spend_diff[MAX_CREDIT_W] ? '0
                                                                 : spend_diff[MAX_CREDIT_W-1:0];
               rr_ptr_d = grant_flow_q;
               state_d  = S_SELECT;
            end
         end

         S_REFILL: begin
            state_d = S_WAIT1;
         end

         S_WAIT1: begin
            state_d = S_WAIT2;
         end

         S_WAIT2: begin
            if (flow_req[ord_flow]) begin
               credit_d[ord_flow] = (refill_sum > CREDIT_MAX) ? CREDIT_MAX[MAX_CREDIT_W-1:0]
                                                              : refill_sum[MAX_CREDIT_W-1:0];
            end
            state_d = S_SELECT;
         end

         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_INIT;
         credit_q      <= '{default: '0};
         rr_ptr_q      <= '1;
         grant_valid_q <= 1'b0;
         grant_flow_q  <= '0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_valid_q <= grant_valid_d;
         grant_flow_q  <= grant_flow_d;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_flow  = grant_flow_q;
   assign ord_rd_req  = (state_q == S_REFILL);
   assign dbg_credit  = credit_q[dbg_flow];

endmodule
